bus_fabric: RTL and testbench
=============================

# bus_fabric

Parametrised interconnect between the picorv32 native memory bus and up to 16 peripheral slaves (memory, gpio, prng, uartTx, timer, …), with one select per slave, a registered read-data mux, and a per-access timeout watchdog. It replaces the shared-bus/address-decoder arrangement at SoC top level, where every peripheral drives `mem_ready`/`mem_rdata`. Unmapped or hung accesses complete with an error response instead of stalling the CPU, and the first error is captured for software.

## Interface
- `NUM_SLAVES`, 8: slaves attached, 1..16; slave i owns address region `mem_addr[31:28] == i`.
- `TIMEOUT`, 255: cycles in ACCESS before abort, 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: `mem_rdata` value on error responses.
- `clk`  in  1  system clock (100 MHz domain).
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  CPU request.
- `mem_instr`  in  1  instruction fetch flag.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  registered read data.
- `s_valid`  out  NUM_SLAVES  one-hot slave request.
- `s_instr`, `s_addr`, `s_wdata`, `s_wstrb`  out  1/32/32/4  registered copies of the CPU request, shared by all slaves.
- `s_ready`  in  NUM_SLAVES  slave completion.
- `s_rdata`  in  32*NUM_SLAVES  slave i's data at bits [32i+31:32i].
- `bus_err`  out  1  one-cycle pulse per error response.
- `err_valid`  out  1  sticky: an error is captured.
- `err_addr`  out  32  address of the first uncleared error.
- `err_cause`  out  2  1 = unmapped, 2 = timeout.
- `err_clr`  in  1  clears `err_valid`/`err_addr`/`err_cause`.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE, `mem_valid`=1:
  - Latch the request into the `s_*` registers.
  - Region < NUM_SLAVES: set `s_valid[region]`, clear the counter, go to ACCESS.
  - Otherwise (unmapped): set `mem_ready`=1, `mem_rdata`=ERR_DATA, `bus_err`=1, cause 1, go to RESP.
- ACCESS:
  - `s_ready[sel]`=1: `mem_ready`=1, `mem_rdata`=`s_rdata[sel]`, drop `s_valid`, go to RESP.
  - Else if counter == TIMEOUT-1: error response (ERR_DATA, cause 2), drop `s_valid`, go to RESP.
  - Else increment the counter.
  - `s_ready` from any unselected slave is ignored.
- RESP: `mem_ready`=0; go to IDLE unconditionally. This guarantees the CPU deasserts `mem_valid` before the next sample.
- Error capture:
  - On an error response with `err_valid`=0, load `err_addr`/`err_cause` and set `err_valid`.
  - While `err_valid`=1, later errors still pulse `bus_err` but do not overwrite the capture.
  - `err_clr` clears the capture; `err_clr` and a new error in the same cycle leave the new error captured.
- `mem_rdata` holds its value between responses. Writes also return `s_rdata[sel]`; the CPU ignores it.
- Counter width is clog2(TIMEOUT+1) and the counter saturates; it never wraps.

## Timing
- Reset: state IDLE; every output 0, including `mem_rdata`, `s_*`, the `err_*` outputs and the counter. Reset mid-access abandons the transaction with no response.
- Mapped access, slave ready in its first `s_valid` cycle:
  - cycle 0: `mem_valid`
  - cycle 1: `s_valid`
  - cycle 2: `mem_ready`
  - Minimum latency is 2 cycles; each slave wait cycle adds 1.
- Unmapped access: `mem_ready` at cycle 1.
- Timeout: `s_valid` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); `mem_ready` and `bus_err` fire at cycle TIMEOUT+1.
- `s_ready` arriving in the last allowed cycle wins over timeout: normal response, no error.
- `s_valid` is never asserted in the `mem_ready` cycle or in RESP.
- Back-to-back accesses: the next `mem_valid` is sampled in the cycle after RESP.

## Structure
- `bus_fabric_pkg`: state enum; cause codes `CAUSE_NONE`/`CAUSE_UNMAPPED`/`CAUSE_TIMEOUT`; `REGION_MSB`=31, `REGION_LSB`=28.
- One sub-module, `bus_watchdog`: the saturating TIMEOUT counter with `start` and `expired` signals. Decode, the read mux and the FSM stay in `bus_fabric`.

## Test plan
- Read from slave 2 (addr 32'h2000_0010), `s_ready[2]` tied high with data 32'h1234_5678 → `s_valid`=3'b100 at cycle 1; `mem_ready` and `mem_rdata`=32'h1234_5678 at cycle 2; `bus_err`=0.
- Write to slave 0, wstrb 4'b0011, slave ready after 3 wait cycles → `s_wdata`/`s_wstrb` stable throughout; `mem_ready` at cycle 5; the following cycle is RESP with no `s_valid`.
- Read from addr 32'hF000_0000 with NUM_SLAVES=8 → `mem_ready` at cycle 1, `mem_rdata`=32'hDEAD_BEEF, `err_cause`=1, `err_addr`=32'hF000_0000.
- TIMEOUT=4, slave 1 never ready → `s_valid[1]` high for 4 cycles; `mem_ready`/`bus_err` at cycle 5; cause 2.
  - Repeat with `s_ready[1]` in cycle 4 → normal response, no error.
- Two errors, the second coincident with `err_clr` → the capture holds the second address. A following error without a clear → `bus_err` pulses, the capture is unchanged.
- Assert `reset` during ACCESS → all outputs 0 immediately. After release, a new read completes normally with 2-cycle latency.

Source files
------------

// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus fabric.
package bus_fabric_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 28;
endpackage

// File: rtl/bus_fabric_if.sv
// CPU native memory bus, shared slave request bus and error-capture sideband.
interface bus_fabric_if #(parameter int NUM_SLAVES = 8);
    logic                    mem_valid;
    logic                    mem_instr;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic [3:0]              mem_wstrb;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;
    logic [NUM_SLAVES-1:0]   s_valid;
    logic                    s_instr;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic [NUM_SLAVES-1:0]   s_ready;
    logic [32*NUM_SLAVES-1:0] s_rdata;
    logic                    bus_err;
    logic                    err_valid;
    logic [31:0]             err_addr;
    logic [1:0]              err_cause;
    logic                    err_clr;

    // The fabric itself: slave to the CPU, master to the peripherals.
    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, s_ready, s_rdata, err_clr,
        output mem_ready, mem_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb,
               bus_err, err_valid, err_addr, err_cause
    );
    // Everything around the fabric: CPU, peripherals and error-reading software.
    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, s_ready, s_rdata, err_clr,
        input  mem_ready, mem_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb,
               bus_err, err_valid, err_addr, err_cause
    );
endinterface

// File: rtl/bus_watchdog.sv
// Saturating per-access cycle counter; expired marks the last allowed ACCESS cycle.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_run,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = '1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_start)
            r_cnt <= '0;
        else if (i_run && r_cnt != MAX)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == LAST);
endmodule

// File: rtl/bus_fabric.sv
// Address-decoded interconnect: one select per 256 MB region, registered read mux,
// timeout watchdog and first-error capture.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int          NUM_SLAVES = 8,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic      clk,
    input  logic      reset,
    bus_fabric_if.slave bus
);
    localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

    state_t                r_state;
    logic                  r_mem_ready;
    logic [31:0]           r_mem_rdata;
    logic [NUM_SLAVES-1:0] r_s_valid;
    logic                  r_s_instr;
    logic [31:0]           r_s_addr;
    logic [31:0]           r_s_wdata;
    logic [3:0]            r_s_wstrb;
    logic                  r_bus_err;
    logic                  r_err_valid;
    logic [31:0]           r_err_addr;
    logic [1:0]            r_err_cause;

    logic [3:0]            w_region;
    logic                  w_mapped;
    logic                  w_hit;
    logic                  w_expired;
    logic [31:0]           w_sel_rdata;
    logic                  w_err;
    logic [1:0]            w_cause;

    assign w_region = bus.mem_addr[REGION_MSB:REGION_LSB];
    assign w_mapped = (32'(w_region) < NUM_SLAVES);
    // r_s_valid is one-hot while in ACCESS, so it doubles as the mux select.
    assign w_hit    = |(bus.s_ready & r_s_valid);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (r_s_valid[i])
                w_sel_rdata = w_sel_rdata | bus.s_rdata[32*i +: 32];
    end

    always_comb begin
        w_err   = 1'b0;
        w_cause = CAUSE_NONE;
        if (r_state == ST_IDLE && bus.mem_valid && !w_mapped) begin
            w_err   = 1'b1;
            w_cause = CAUSE_UNMAPPED;
        end else if (r_state == ST_ACCESS && !w_hit && w_expired) begin
            w_err   = 1'b1;
            w_cause = CAUSE_TIMEOUT;
        end
    end

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (reset),
        .i_start   (r_state == ST_IDLE && bus.mem_valid && w_mapped),
        .i_run     (r_state == ST_ACCESS),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_s_valid   <= '0;
            r_s_instr   <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_bus_err   <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_cause <= CAUSE_NONE;
        end else begin
            r_mem_ready <= 1'b0;
            r_bus_err   <= w_err;
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_valid) begin
                        r_s_instr <= bus.mem_instr;
                        r_s_addr  <= bus.mem_addr;
                        r_s_wdata <= bus.mem_wdata;
                        r_s_wstrb <= bus.mem_wstrb;
                        if (w_mapped) begin
                            r_s_valid <= SEL_ONE << w_region;
                            r_state   <= ST_ACCESS;
                        end else begin
                            r_mem_ready <= 1'b1;
                            r_mem_rdata <= ERR_DATA;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    // A ready in the last allowed cycle takes priority over the timeout.
                    if (w_hit || w_expired) begin
                        r_mem_ready <= 1'b1;
                        r_mem_rdata <= w_hit ? w_sel_rdata : ERR_DATA;
                        r_s_valid   <= '0;
                        r_state     <= ST_RESP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A clear coincident with a new error yields the new error.
            if (w_err && (!r_err_valid || bus.err_clr)) begin
                r_err_valid <= 1'b1;
                r_err_addr  <= r_state == ST_IDLE ? bus.mem_addr : r_s_addr;
                r_err_cause <= w_cause;
            end else if (bus.err_clr) begin
                r_err_valid <= 1'b0;
                r_err_addr  <= '0;
                r_err_cause <= CAUSE_NONE;
            end
        end
    end

    assign bus.mem_ready = r_mem_ready;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.s_valid   = r_s_valid;
    assign bus.s_instr   = r_s_instr;
    assign bus.s_addr    = r_s_addr;
    assign bus.s_wdata   = r_s_wdata;
    assign bus.s_wstrb   = r_s_wstrb;
    assign bus.bus_err   = r_bus_err;
    assign bus.err_valid = r_err_valid;
    assign bus.err_addr  = r_err_addr;
    assign bus.err_cause = r_err_cause;
endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: cycle-accurate access checks with a response scoreboard.
module tb_bus_fabric;
    import bus_fabric_pkg::*;

    localparam int          NS = 8;
    localparam int          TO = 4;
    localparam logic [31:0] ED = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_fabric_if #(.NUM_SLAVES(NS)) bus();

    bus_fabric #(.NUM_SLAVES(NS), .TIMEOUT(TO), .ERR_DATA(ED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] slv_data(input int i);
        return (i == 2) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i * 257));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, ".mem_ready"}, 32'(bus.mem_ready), 0);
        chk({pfx, ".mem_rdata"}, bus.mem_rdata, 0);
        chk({pfx, ".s_valid"},   32'(bus.s_valid), 0);
        chk({pfx, ".s_instr"},   32'(bus.s_instr), 0);
        chk({pfx, ".s_addr"},    bus.s_addr, 0);
        chk({pfx, ".s_wdata"},   bus.s_wdata, 0);
        chk({pfx, ".s_wstrb"},   32'(bus.s_wstrb), 0);
        chk({pfx, ".bus_err"},   32'(bus.bus_err), 0);
        chk({pfx, ".err_valid"}, 32'(bus.err_valid), 0);
        chk({pfx, ".err_addr"},  bus.err_addr, 0);
        chk({pfx, ".err_cause"}, 32'(bus.err_cause), 0);
    endtask

    task automatic chk_cap(input logic v, input logic [31:0] a, input logic [1:0] c);
        chk("err_valid", 32'(bus.err_valid), 32'(v));
        chk("err_addr",  bus.err_addr, a);
        chk("err_cause", 32'(bus.err_cause), 32'(c));
    endtask

    // rdy_cyc: cycle in which the selected slave pulses s_ready (-1 = never).
    // clr_cyc: cycle in which err_clr is driven (-1 = never).
    task automatic xfer(input logic [31:0] addr, input logic instr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input int rdy_cyc, input int clr_cyc);
        int              region;
        bit              mapped;
        int              lat;
        bit              done;
        exp_t            e;
        logic [NS-1:0]   oh;
        region = int'(addr[31:28]);
        mapped = region < NS;
        oh     = mapped ? (NS'(1) << region) : '0;
        done   = 1'b0;
        if (!mapped) begin
            lat = 1;
            e   = '{ED, 1'b1};
        end else if (rdy_cyc >= 1 && rdy_cyc <= TO) begin
            lat = rdy_cyc + 1;
            e   = '{slv_data(region), 1'b0};
        end else begin
            lat = TO + 1;
            e   = '{ED, 1'b1};
        end
        sbq.push_back(e);

        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_instr = instr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        for (int cyc = 0; cyc <= TO + 2 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            // Unselected slaves assert ready while waiting; the fabric must ignore them.
            bus.s_ready = (cyc > 0 && cyc == rdy_cyc) ? oh : (cyc > 0 ? ~oh : '0);
            bus.err_clr = (cyc == clr_cyc);
            @(negedge clk);
            chk("s_valid",   32'(bus.s_valid), (cyc >= 1 && cyc < lat) ? 32'(oh) : 0);
            chk("mem_ready", 32'(bus.mem_ready), 32'(cyc == lat));
            if (cyc >= 1) begin
                chk("s_addr",  bus.s_addr, addr);
                chk("s_wdata", bus.s_wdata, wdata);
                chk("s_wstrb", 32'(bus.s_wstrb), 32'(wstrb));
                chk("s_instr", 32'(bus.s_instr), 32'(instr));
            end
            if (bus.mem_ready) begin
                e = sbq.pop_front();
                chk("mem_rdata", bus.mem_rdata, e.rdata);
                chk("bus_err",   32'(bus.bus_err), 32'(e.err));
                done = 1'b1;
            end else begin
                chk("bus_err_idle", 32'(bus.bus_err), 0);
            end
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL resp_wait: observed no mem_ready, expected one by cycle %0d", lat);
            if (sbq.size() != 0) e = sbq.pop_front();
        end

        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = '0;
        bus.s_ready   = '0;
        bus.err_clr   = 1'b0;
        @(negedge clk);
        chk("post_s_valid",   32'(bus.s_valid), 0);
        chk("post_mem_ready", 32'(bus.mem_ready), 0);
        chk("post_bus_err",   32'(bus.bus_err), 0);
        chk("rdata_hold",     bus.mem_rdata, e.rdata);
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk_cap(1'b0, 32'h0, CAUSE_NONE);
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.s_ready   = '0;
        bus.err_clr   = 1'b0;
        for (int i = 0; i < NS; i++)
            bus.s_rdata[32*i +: 32] = slv_data(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        xfer(32'h2000_0010, 1'b1, 4'b0000, 32'h0,          1, -1);
        xfer(32'h0000_0040, 1'b0, 4'b0011, 32'h55AA_1234,  4, -1);
        xfer(32'hF000_0000, 1'b0, 4'b0000, 32'h0,          1, -1);
        chk_cap(1'b1, 32'hF000_0000, CAUSE_UNMAPPED);
        clear_err();

        xfer(32'h1000_0004, 1'b0, 4'b0000, 32'h0,         -1, -1);
        chk_cap(1'b1, 32'h1000_0004, CAUSE_TIMEOUT);
        xfer(32'h1000_0008, 1'b0, 4'b0000, 32'h0,          4, -1);
        chk_cap(1'b1, 32'h1000_0004, CAUSE_TIMEOUT);
        clear_err();

        xfer(32'h9000_0000, 1'b0, 4'b0000, 32'h0,         -1, -1);
        chk_cap(1'b1, 32'h9000_0000, CAUSE_UNMAPPED);
        xfer(32'hA000_0000, 1'b0, 4'b0000, 32'h0,         -1,  0);
        chk_cap(1'b1, 32'hA000_0000, CAUSE_UNMAPPED);
        xfer(32'h3000_0000, 1'b0, 4'b1111, 32'hFFFF_0000, -1, -1);
        chk_cap(1'b1, 32'hA000_0000, CAUSE_UNMAPPED);

        // Reset asserted while the access to slave 5 is waiting.
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h5000_0000;
        bus.mem_wstrb = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_s_valid", 32'(bus.s_valid), 32'h20);
        #1 reset = 1'b1;
        #1 chk_zero("midreset");
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.mem_valid = 1'b0;
        xfer(32'h5000_0020, 1'b0, 4'b0000, 32'h0,          1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
